instr_dcd_wide: RTL and testbench

INSTR_DCD_WIDE -- requirements
Module: instr_dcd_wide

---
 rtl/instr_dcd_wide.sv | 181 ++++++++++++++++++
 tb/tb_instr_dcd_wide.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_dcd_wide.sv
`default_nettype none
// ============================================================================
// instr_dcd_wide : SPI byte-stream header/data decoder driving register strobes
// Optional burst auto-increment via macro INSTR_DCD_WIDE_BURST_EN.
// Revision: 1.0
// ============================================================================
module instr_dcd_wide #(
    parameter int ADDR_W     = 6,
    parameter int DATA_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cs_n,
    input  logic                    byte_sync,
    input  logic [7:0]              data_in,
    output logic [7:0]              data_out,
    output logic                    read,
    output logic                    write,
    output logic [ADDR_W-1:0]       addr,
    input  logic [8*DATA_BYTES-1:0] data_read,
    output logic [8*DATA_BYTES-1:0] data_write,
    output logic                    busy
);
    localparam int DW        = 8 * DATA_BYTES;
    localparam int HDR_BYTES = (ADDR_W <= 6) ? 1 : 2;
    localparam int MAX_BYTES = (HDR_BYTES > DATA_BYTES) ? HDR_BYTES : DATA_BYTES;
    localparam int IDX_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    localparam logic [IDX_W-1:0] HDR_LAST  = IDX_W'(HDR_BYTES - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BYTES - 1);

    localparam logic [0:0] S_HDR  = 1'b0;
    localparam logic [0:0] S_DATA = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              rw_q, hl_q, read_q, write_q, rd_dly_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DW-1:0]     shadow_q, wdata_q;
    logic [ADDR_W-1:0] w_hdr_addr;
    logic              w_take, w_hdr_first, w_hdr_last, w_data_byte, w_word_last, w_rw_hdr;
    int                w_lane;

    assign w_take      = !cs_n && byte_sync;
    assign w_hdr_first = w_take && (state_q == S_HDR) && (idx_q == '0);
    assign w_hdr_last  = w_take && (state_q == S_HDR) && (idx_q == HDR_LAST);
    assign w_data_byte = w_take && (state_q == S_DATA);
    assign w_word_last = w_data_byte && (idx_q == DATA_LAST);
    // With a one-byte header rw arrives in the same byte that ends the header.
    assign w_rw_hdr    = (idx_q == '0) ? data_in[7] : rw_q;

    always_comb begin
        w_lane = hl_q ? (DATA_BYTES - 1 - int'(idx_q)) : int'(idx_q);
    end

    generate
        if (ADDR_W <= 8) begin : g_hdr_narrow
            assign w_hdr_addr = data_in[ADDR_W-1:0];
        end else begin : g_hdr_wide
            logic [5:0] hdr0_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hdr0_q <= '0;
                end else if (w_hdr_first) begin
                    hdr0_q <= data_in[5:0];
                end
            end
            assign w_hdr_addr = {hdr0_q[ADDR_W-9:0], data_in};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HDR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (cs_n) begin
            state_d = S_HDR;
            idx_d   = '0;
        end else if (byte_sync) begin
            case (state_q)
                S_HDR: begin
                    if (idx_q == HDR_LAST) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: begin
                    if (idx_q == DATA_LAST) begin
                        idx_d = '0;
`ifdef INSTR_DCD_WIDE_BURST_EN
                        state_d = S_DATA;
`else
                        state_d = S_HDR;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        busy     = (state_q != S_HDR) || (idx_q != '0);
        data_out = '0;
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (b == w_lane) data_out = shadow_q[8*b +: 8];
        end
    end

`ifdef INSTR_DCD_WIDE_BURST_EN
    logic inc_pend_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q     <= 1'b0;
            hl_q     <= 1'b0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            rd_dly_q <= 1'b0;
            addr_q   <= '0;
            shadow_q <= '0;
            wdata_q  <= '0;
`ifdef INSTR_DCD_WIDE_BURST_EN
            inc_pend_q <= 1'b0;
`endif
        end else begin
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            rd_dly_q <= read_q;
            // Register file returns data one cycle after the read strobe.
            if (rd_dly_q) shadow_q <= data_read;
            if (w_hdr_first) begin
                rw_q <= data_in[7];
                hl_q <= data_in[6];
            end
            if (w_hdr_last) begin
                addr_q <= w_hdr_addr;
                read_q <= ~w_rw_hdr;
            end
            if (w_data_byte && rw_q) begin
                for (int b = 0; b < DATA_BYTES; b++) begin
                    if (b == w_lane) wdata_q[8*b +: 8] <= data_in;
                end
            end
            if (w_word_last && rw_q) write_q <= 1'b1;
`ifdef INSTR_DCD_WIDE_BURST_EN
            // Write bursts step the address only after the strobe has been seen.
            inc_pend_q <= 1'b0;
            if (inc_pend_q && !cs_n) addr_q <= addr_q + 1'b1;
            if (w_word_last) begin
                if (rw_q) begin
                    inc_pend_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + 1'b1;
                    read_q <= 1'b1;
                end
            end
`endif
        end
    end

    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign data_write = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_dcd_wide.sv
`default_nettype none
// tb_instr_dcd_wide : directed and randomized checks of instr_dcd_wide against
// a frame-level reference model (default build plus an ADDR_W=10 instance).
module tb_instr_dcd_wide;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cs_n = 1'b1;
    logic        byte_sync = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [15:0] data_read = 16'h0000;

    logic [7:0]  data_out, wd_data_out;
    logic        read, write, busy, wd_read, wd_write, wd_busy;
    logic [5:0]  addr;
    logic [9:0]  wd_addr;
    logic [15:0] data_write, wd_data_write;

    int pass_cnt = 0;
    int check_cnt = 0;
    int both_cnt = 0;

    typedef struct {
        bit          wr;
        int unsigned a;
        int unsigned d;
    } ev_t;

    ev_t obs_q[$], wobs_q[$], exp_q[$];
    int  obs_dout[$], obs_busy[$], exp_dout[$], exp_busy[$];

    instr_dcd_wide u_dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .byte_sync(byte_sync),
        .data_in(data_in), .data_out(data_out), .read(read), .write(write),
        .addr(addr), .data_read(data_read), .data_write(data_write), .busy(busy)
    );

    instr_dcd_wide #(.ADDR_W(10), .DATA_BYTES(2)) u_wide (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .byte_sync(byte_sync),
        .data_in(data_in), .data_out(wd_data_out), .read(wd_read), .write(wd_write),
        .addr(wd_addr), .data_read(data_read), .data_write(wd_data_write), .busy(wd_busy)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk_ev(input bit wr, input int unsigned a, input int unsigned d);
        ev_t e;
        e.wr = wr;
        e.a  = a;
        e.d  = d;
        return e;
    endfunction

    always @(negedge clk) begin
        if (read && write) both_cnt++;
        if (read)     obs_q.push_back(mk_ev(1'b0, 32'(addr), 32'd0));
        if (write)    obs_q.push_back(mk_ev(1'b1, 32'(addr), 32'(data_write)));
        if (wd_read)  wobs_q.push_back(mk_ev(1'b0, 32'(wd_addr), 32'd0));
        if (wd_write) wobs_q.push_back(mk_ev(1'b1, 32'(wd_addr), 32'(wd_data_write)));
    end

    // Frame-level model of the default build (6-bit address, 2-byte words).
    function automatic void model(input byte unsigned b[$], input int unsigned dread);
        bit          in_hdr = 1'b1;
        bit          rw = 1'b0;
        bit          hl = 1'b0;
        int unsigned a = 0;
        int unsigned wv = 0;
        int          cnt = 0;
        int          lane;
        exp_q.delete(); exp_dout.delete(); exp_busy.delete();
        foreach (b[i]) begin
            if (in_hdr) begin
                rw = b[i][7];
                hl = b[i][6];
                a  = 32'(b[i]) & 32'h3F;
                in_hdr = 1'b0;
                cnt = 0;
                wv  = 0;
                if (!rw) exp_q.push_back(mk_ev(1'b0, a, 0));
                exp_dout.push_back(-1);
            end else begin
                lane = hl ? (1 - cnt) : cnt;
                exp_dout.push_back(rw ? -1 : int'((dread >> (8 * lane)) & 32'hFF));
                if (rw) wv = wv | (32'(b[i]) << (8 * lane));
                cnt++;
                if (cnt == 2) begin
                    cnt = 0;
                    if (rw) exp_q.push_back(mk_ev(1'b1, a, wv));
                    wv = 0;
`ifdef INSTR_DCD_WIDE_BURST_EN
                    a = (a + 1) % 64;
                    if (!rw) exp_q.push_back(mk_ev(1'b0, a, 0));
`else
                    in_hdr = 1'b1;
`endif
                end
            end
            exp_busy.push_back(in_hdr ? 0 : 1);
        end
    endfunction

    task automatic send_byte(input byte unsigned v, input bit with_abort);
        data_in   = v;
        byte_sync = 1'b1;
        if (with_abort) cs_n = 1'b1;
        @(negedge clk);
        byte_sync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input byte unsigned b[$], input bit abort_last);
        obs_dout.delete(); obs_busy.delete();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        foreach (b[i]) begin
            obs_dout.push_back(int'(data_out));
            send_byte(b[i], abort_last && (i == b.size() - 1));
            obs_busy.push_back(int'(busy));
        end
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        check_cnt++; if (data_out !== 8'h00) $display("FAIL reset_data_out got %h want 00", data_out); else pass_cnt++;
        check_cnt++; if (read !== 1'b0) $display("FAIL reset_read got %b want 0", read); else pass_cnt++;
        check_cnt++; if (write !== 1'b0) $display("FAIL reset_write got %b want 0", write); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        check_cnt++; if (addr !== 6'h00) $display("FAIL reset_addr got %h want 00", addr); else pass_cnt++;
        check_cnt++; if (data_write !== 16'h0000) $display("FAIL reset_data_write got %h want 0000", data_write); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        byte unsigned q[$];
        q = '{8'hC5, 8'h12, 8'h34};
        obs_q.delete();
        send_frame(q, 1'b0);
        check_cnt++; if (obs_q.size() != 1) $display("FAIL write_strobes got %0d want 1", obs_q.size()); else pass_cnt++;
        if (obs_q.size() > 0) begin
            check_cnt++; if (obs_q[0].wr !== 1'b1) $display("FAIL write_kind got read want write"); else pass_cnt++;
            check_cnt++; if (obs_q[0].a != 32'h05) $display("FAIL write_addr got %h want 05", obs_q[0].a); else pass_cnt++;
            check_cnt++; if (obs_q[0].d != 32'h1234) $display("FAIL write_data got %h want 1234", obs_q[0].d); else pass_cnt++;
        end
        check_cnt++; if (obs_busy[0] != 1) $display("FAIL write_busy_mid got %0d want 1", obs_busy[0]); else pass_cnt++;
        check_cnt++; if (obs_busy[2] != 0) $display("FAIL write_busy_end got %0d want 0", obs_busy[2]); else pass_cnt++;
    endtask

    task automatic test_read_lsb_first();
        byte unsigned q[$];
        q = '{8'h0A, 8'h55, 8'h66};
        data_read = 16'hBEEF;
        obs_q.delete();
        send_frame(q, 1'b0);
        check_cnt++; if (obs_q.size() != 1) $display("FAIL read_strobes got %0d want 1", obs_q.size()); else pass_cnt++;
        if (obs_q.size() > 0) begin
            check_cnt++; if (obs_q[0].wr !== 1'b0) $display("FAIL read_kind got write want read"); else pass_cnt++;
            check_cnt++; if (obs_q[0].a != 32'h0A) $display("FAIL read_addr got %h want 0a", obs_q[0].a); else pass_cnt++;
        end
        check_cnt++; if (obs_dout[1] != 32'hEF) $display("FAIL read_byte0 got %h want ef", obs_dout[1]); else pass_cnt++;
        check_cnt++; if (obs_dout[2] != 32'hBE) $display("FAIL read_byte1 got %h want be", obs_dout[2]); else pass_cnt++;
    endtask

    task automatic test_abort();
        byte unsigned q[$];
        q = '{8'h85, 8'hAA};
        obs_q.delete();
        send_frame(q, 1'b0);
        check_cnt++; if (obs_q.size() != 0) $display("FAIL abort_strobes got %0d want 0", obs_q.size()); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else pass_cnt++;
        q = '{8'hC5, 8'h12, 8'h34};
        obs_q.delete();
        send_frame(q, 1'b1);
        check_cnt++; if (obs_q.size() != 0) $display("FAIL abort_race_strobes got %0d want 0", obs_q.size()); else pass_cnt++;
        q = '{8'h81, 8'h01, 8'h02};
        obs_q.delete();
        send_frame(q, 1'b0);
        check_cnt++; if (obs_q.size() != 1) $display("FAIL after_abort_strobes got %0d want 1", obs_q.size()); else pass_cnt++;
        if (obs_q.size() > 0) begin
            check_cnt++; if (obs_q[0].a != 32'h01 || obs_q[0].d != 32'h0201 || obs_q[0].wr !== 1'b1)
                $display("FAIL after_abort_write got wr=%0d a=%h d=%h want wr=1 a=01 d=0201", obs_q[0].wr, obs_q[0].a, obs_q[0].d);
            else pass_cnt++;
        end
    endtask

    task automatic test_burst_stream();
        byte unsigned q[$];
        ev_t want[$];
        q = '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
        want.push_back(mk_ev(1'b1, 32'h3F, 32'h1122));
`ifdef INSTR_DCD_WIDE_BURST_EN
        want.push_back(mk_ev(1'b1, 32'h00, 32'h3344));
`else
        want.push_back(mk_ev(1'b0, 32'h33, 32'h0));
`endif
        obs_q.delete();
        send_frame(q, 1'b0);
        check_cnt++; if (obs_q.size() != want.size()) $display("FAIL stream_strobes got %0d want %0d", obs_q.size(), want.size()); else pass_cnt++;
        for (int k = 0; k < obs_q.size() && k < want.size(); k++) begin
            check_cnt++;
            if (obs_q[k].wr !== want[k].wr || obs_q[k].a != want[k].a || (want[k].wr && obs_q[k].d != want[k].d))
                $display("FAIL stream_ev%0d got wr=%0d a=%h d=%h want wr=%0d a=%h d=%h", k,
                         obs_q[k].wr, obs_q[k].a, obs_q[k].d, want[k].wr, want[k].a, want[k].d);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        byte unsigned q[$];
        int unsigned  dr;
        for (int f = 0; f < 25; f++) begin
            q.delete();
            dr = $urandom & 32'hFFFF;
            data_read = dr[15:0];
            for (int n = 0; n < int'($urandom_range(1, 6)); n++) q.push_back(8'($urandom));
            model(q, dr);
            obs_q.delete();
            send_frame(q, 1'b0);
            check_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL rand%0d_strobes got %0d want %0d", f, obs_q.size(), exp_q.size()); else pass_cnt++;
            for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
                check_cnt++;
                if (obs_q[k].wr !== exp_q[k].wr || obs_q[k].a != exp_q[k].a || (exp_q[k].wr && obs_q[k].d != exp_q[k].d))
                    $display("FAIL rand%0d_ev%0d got wr=%0d a=%h d=%h want wr=%0d a=%h d=%h", f, k,
                             obs_q[k].wr, obs_q[k].a, obs_q[k].d, exp_q[k].wr, exp_q[k].a, exp_q[k].d);
                else pass_cnt++;
            end
            foreach (q[i]) begin
                if (exp_dout[i] >= 0) begin
                    check_cnt++; if (obs_dout[i] != exp_dout[i]) $display("FAIL rand%0d_dout%0d got %h want %h", f, i, obs_dout[i], exp_dout[i]); else pass_cnt++;
                end
                check_cnt++; if (obs_busy[i] != exp_busy[i]) $display("FAIL rand%0d_busy%0d got %0d want %0d", f, i, obs_busy[i], exp_busy[i]); else pass_cnt++;
            end
        end
        check_cnt++; if (both_cnt != 0) $display("FAIL read_write_overlap got %0d want 0", both_cnt); else pass_cnt++;
    endtask

    task automatic test_wide_addr_and_reset();
        data_read = 16'hBEEF;
        wobs_q.delete();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h41, 1'b0);
        check_cnt++; if (wd_busy !== 1'b1) $display("FAIL wide_busy_partial_hdr got %b want 1", wd_busy); else pass_cnt++;
        send_byte(8'h23, 1'b0);
        check_cnt++; if (wobs_q.size() != 1) $display("FAIL wide_read_strobes got %0d want 1", wobs_q.size()); else pass_cnt++;
        if (wobs_q.size() > 0) begin
            check_cnt++; if (wobs_q[0].wr !== 1'b0 || wobs_q[0].a != 32'h123)
                $display("FAIL wide_read got wr=%0d a=%h want wr=0 a=123", wobs_q[0].wr, wobs_q[0].a);
            else pass_cnt++;
        end
        check_cnt++; if (wd_data_out !== 8'hBE) $display("FAIL wide_msb_first got %h want be", wd_data_out); else pass_cnt++;
        send_byte(8'h77, 1'b0);
        check_cnt++; if (wd_data_out !== 8'hEF) $display("FAIL wide_second_byte got %h want ef", wd_data_out); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++; if (wd_busy !== 1'b0 || wd_read !== 1'b0 || wd_write !== 1'b0)
            $display("FAIL wide_async_reset_ctrl got busy=%b read=%b write=%b want 0 0 0", wd_busy, wd_read, wd_write);
        else pass_cnt++;
        check_cnt++; if (wd_addr !== 10'h000 || wd_data_out !== 8'h00 || wd_data_write !== 16'h0000)
            $display("FAIL wide_async_reset_data got addr=%h dout=%h dw=%h want 0 0 0", wd_addr, wd_data_out, wd_data_write);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        wobs_q.delete();
        repeat (2) @(negedge clk);
        send_byte(8'h80, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check_cnt++; if (wobs_q.size() != 1) $display("FAIL wide_post_reset_strobes got %0d want 1", wobs_q.size()); else pass_cnt++;
        if (wobs_q.size() > 0) begin
            check_cnt++; if (wobs_q[0].wr !== 1'b1 || wobs_q[0].a != 32'h005 || wobs_q[0].d != 32'hCDAB)
                $display("FAIL wide_post_reset_write got wr=%0d a=%h d=%h want wr=1 a=005 d=cdab", wobs_q[0].wr, wobs_q[0].a, wobs_q[0].d);
            else pass_cnt++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write();
        test_read_lsb_first();
        test_abort();
        test_burst_stream();
        test_random();
        test_wide_addr_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
`default_nettype wire
